// File: rtl/sr_flop_bank.sv
// Bank of WIDTH clocked SR flip-flops with configurable S=R=1 resolution,
// per-bit edge pulses and a sticky/saturating conflict monitor.
module sr_flop_bank #(
    parameter int                 WIDTH         = 8,
    parameter int                 CONFLICT_MODE = 0,
    parameter logic [WIDTH-1:0]   RESET_VAL     = {WIDTH{1'b0}},
    parameter int                 CNT_W         = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               sclr,
    input  logic [WIDTH-1:0]   s,
    input  logic [WIDTH-1:0]   r,
    input  logic               err_clr,
    output logic [WIDTH-1:0]   q,
    output logic [WIDTH-1:0]   qb,
    output logic [WIDTH-1:0]   rise,
    output logic [WIDTH-1:0]   fall,
    output logic               conflict_seen,
    output logic [CNT_W-1:0]   conflict_cnt
);

    // Out-of-range modes collapse to hold so S=R=1 always has a defined result.
    localparam int MODE = (CONFLICT_MODE >= 0 && CONFLICT_MODE <= 3) ? CONFLICT_MODE : 0;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] rise_q, fall_q;
    logic             seen_q, seen_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             conflictEvent;

    always_comb begin
        q_d = q_q;
        if (sclr) begin
            q_d = RESET_VAL;
        end else if (en) begin
            for (int i = 0; i < WIDTH; i++) begin
                case ({s[i], r[i]})
                    2'b01:   q_d[i] = 1'b0;
                    2'b10:   q_d[i] = 1'b1;
                    2'b11: begin
                        case (MODE)
                            1:       q_d[i] = 1'b1;
                            2:       q_d[i] = 1'b0;
                            3:       q_d[i] = ~q_q[i];
                            default: q_d[i] = q_q[i];
                        endcase
                    end
                    default: q_d[i] = q_q[i];
                endcase
            end
        end
    end

    // A conflict cycle counts once no matter how many bits collide; a
    // simultaneous err_clr loses to the new event.
    assign conflictEvent = en & ~sclr & (|(s & r));

    always_comb begin
        seen_d = seen_q;
        cnt_d  = cnt_q;
        if (conflictEvent) begin
            seen_d = 1'b1;
            if (err_clr) begin
                cnt_d = CNT_W'(1);
            end else if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (err_clr) begin
            seen_d = 1'b0;
            cnt_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q    <= RESET_VAL;
            rise_q <= '0;
            fall_q <= '0;
            seen_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            q_q    <= q_d;
            rise_q <= q_d & ~q_q;
            fall_q <= ~q_d & q_q;
            seen_q <= seen_d;
            cnt_q  <= cnt_d;
        end
    end

    assign q             = q_q;
    assign qb            = ~q_q;
    assign rise          = rise_q;
    assign fall          = fall_q;
    assign conflict_seen = seen_q;
    assign conflict_cnt  = cnt_q;

endmodule

// File: tb/tb_sr_flop_bank.sv
// Directed bench for sr_flop_bank: four instances (one per CONFLICT_MODE)
// share the same stimulus so every mode is checked against hand values.
module tb_sr_flop_bank;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       sclr;
    logic [7:0] s;
    logic [7:0] r;
    logic       err_clr;

    logic [7:0] q    [4];
    logic [7:0] qb   [4];
    logic [7:0] rise [4];
    logic [7:0] fall [4];
    logic       seen [4];
    logic [2:0] cnt  [4];

    int checks   = 0;
    int failures = 0;

    sr_flop_bank #(.WIDTH(8), .CONFLICT_MODE(0), .RESET_VAL(8'hA5), .CNT_W(3)) dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .sclr(sclr), .s(s), .r(r), .err_clr(err_clr),
        .q(q[0]), .qb(qb[0]), .rise(rise[0]), .fall(fall[0]),
        .conflict_seen(seen[0]), .conflict_cnt(cnt[0]));
    sr_flop_bank #(.WIDTH(8), .CONFLICT_MODE(1), .RESET_VAL(8'hA5), .CNT_W(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .sclr(sclr), .s(s), .r(r), .err_clr(err_clr),
        .q(q[1]), .qb(qb[1]), .rise(rise[1]), .fall(fall[1]),
        .conflict_seen(seen[1]), .conflict_cnt(cnt[1]));
    sr_flop_bank #(.WIDTH(8), .CONFLICT_MODE(2), .RESET_VAL(8'hA5), .CNT_W(3)) dut2 (
        .clk(clk), .rst_n(rst_n), .en(en), .sclr(sclr), .s(s), .r(r), .err_clr(err_clr),
        .q(q[2]), .qb(qb[2]), .rise(rise[2]), .fall(fall[2]),
        .conflict_seen(seen[2]), .conflict_cnt(cnt[2]));
    sr_flop_bank #(.WIDTH(8), .CONFLICT_MODE(3), .RESET_VAL(8'hA5), .CNT_W(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .en(en), .sclr(sclr), .s(s), .r(r), .err_clr(err_clr),
        .q(q[3]), .qb(qb[3]), .rise(rise[3]), .fall(fall[3]),
        .conflict_seen(seen[3]), .conflict_cnt(cnt[3]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic applyStimulus(input logic enV, input logic sclrV, input logic [7:0] sV,
                                 input logic [7:0] rV, input logic errClrV);
        en      = enV;
        sclr    = sclrV;
        s       = sV;
        r       = rV;
        err_clr = errClrV;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    logic [7:0] modeQ    [4] = '{8'h0F, 8'hFF, 8'h00, 8'hF0};
    logic [7:0] modeRise [4] = '{8'h00, 8'hF0, 8'h00, 8'hF0};
    logic [7:0] modeFall [4] = '{8'h00, 8'h00, 8'h0F, 8'h0F};

    initial begin
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        #1 rst_n = 1'b0;
        #2;
        for (int k = 0; k < 4; k++) checkOutput($sformatf("rst_q%0d", k), 32'(q[k]), 32'hA5);
        checkOutput("rst_qb", 32'(qb[0]), 32'h5A);
        checkOutput("rst_rise", 32'(rise[0]), 32'h0);
        checkOutput("rst_fall", 32'(fall[0]), 32'h0);
        checkOutput("rst_seen", 32'(seen[0]), 32'h0);
        checkOutput("rst_cnt", 32'(cnt[0]), 32'h0);

        #4 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("idle_q", 32'(q[0]), 32'hA5);
            checkOutput("idle_edges", 32'({rise[0], fall[0]}), 32'h0);
        end

        $display("[TB] basic set/reset");
        applyStimulus(1'b1, 1'b0, 8'h00, 8'hFF, 1'b0);
        tick();
        checkOutput("clr_q", 32'(q[0]), 32'h00);
        checkOutput("clr_fall", 32'(fall[0]), 32'hA5);
        applyStimulus(1'b1, 1'b0, 8'h0F, 8'h00, 1'b0);
        tick();
        checkOutput("set_q", 32'(q[1]), 32'h0F);
        checkOutput("set_rise", 32'(rise[1]), 32'h0F);
        checkOutput("set_fall", 32'(fall[1]), 32'h00);
        applyStimulus(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
        tick();
        checkOutput("hold_rise", 32'(rise[1]), 32'h00);
        checkOutput("hold_q", 32'(q[1]), 32'h0F);
        applyStimulus(1'b1, 1'b0, 8'h00, 8'h03, 1'b0);
        tick();
        checkOutput("rst_bits_q", 32'(q[2]), 32'h0C);
        checkOutput("rst_bits_fall", 32'(fall[2]), 32'h03);
        checkOutput("rst_bits_qb", 32'(qb[2]), 32'hF3);
        applyStimulus(1'b1, 1'b0, 8'h03, 8'h00, 1'b0);
        tick();
        checkOutput("reset_q", 32'(q[3]), 32'h0F);
        checkOutput("reset_rise", 32'(rise[3]), 32'h03);
        checkOutput("no_conflict_cnt", 32'(cnt[3]), 32'h0);

        $display("[TB] conflict modes");
        applyStimulus(1'b1, 1'b0, 8'hFF, 8'hFF, 1'b0);
        tick();
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("mode%0d_q", k), 32'(q[k]), 32'(modeQ[k]));
            checkOutput($sformatf("mode%0d_rise", k), 32'(rise[k]), 32'(modeRise[k]));
            checkOutput($sformatf("mode%0d_fall", k), 32'(fall[k]), 32'(modeFall[k]));
            checkOutput($sformatf("mode%0d_seen", k), 32'(seen[k]), 32'h1);
            checkOutput($sformatf("mode%0d_cnt", k), 32'(cnt[k]), 32'h1);
        end

        $display("[TB] enable and clear priority");
        applyStimulus(1'b0, 1'b0, 8'hFF, 8'h00, 1'b0);
        tick();
        checkOutput("en0_q", 32'(q[0]), 32'h0F);
        checkOutput("en0_q3", 32'(q[3]), 32'hF0);
        checkOutput("en0_cnt", 32'(cnt[0]), 32'h1);
        applyStimulus(1'b1, 1'b1, 8'hFF, 8'hFF, 1'b0);
        tick();
        for (int k = 0; k < 4; k++) checkOutput($sformatf("sclr_q%0d", k), 32'(q[k]), 32'hA5);
        checkOutput("sclr_cnt", 32'(cnt[0]), 32'h1);
        checkOutput("sclr_seen", 32'(seen[0]), 32'h1);
        checkOutput("sclr_rise", 32'(rise[0]), 32'hA0);
        checkOutput("sclr_fall", 32'(fall[0]), 32'h0A);

        applyStimulus(1'b1, 1'b0, 8'h0F, 8'h00, 1'b0);
        tick();
        checkOutput("pre_async_q", 32'(q[0]), 32'hAF);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_q", 32'(q[0]), 32'hA5);
        checkOutput("async_rise", 32'(rise[0]), 32'h0);
        checkOutput("async_seen", 32'(seen[0]), 32'h0);
        checkOutput("async_cnt", 32'(cnt[0]), 32'h0);
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        #1 rst_n = 1'b1;

        $display("[TB] counter saturation");
        applyStimulus(1'b1, 1'b0, 8'h01, 8'h01, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            tick();
            checkOutput($sformatf("sat_cnt%0d", i), 32'(cnt[0]), (i > 7) ? 32'd7 : 32'(i));
            checkOutput($sformatf("sat_seen%0d", i), 32'(seen[3]), 32'h1);
        end
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
        tick();
        checkOutput("errclr_cnt", 32'(cnt[0]), 32'h0);
        checkOutput("errclr_seen", 32'(seen[0]), 32'h0);
        applyStimulus(1'b1, 1'b0, 8'h01, 8'h01, 1'b1);
        tick();
        checkOutput("errclr_evt_cnt", 32'(cnt[2]), 32'h1);
        checkOutput("errclr_evt_seen", 32'(seen[2]), 32'h1);

        $display("[TB] toggle stress");
        applyStimulus(1'b1, 1'b0, 8'h00, 8'hFF, 1'b0);
        tick();
        checkOutput("tgl_start_q", 32'(q[3]), 32'h00);
        applyStimulus(1'b1, 1'b0, 8'h01, 8'h01, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput($sformatf("tgl_q%0d", i), 32'(q[3][0]), (i % 2 == 0) ? 32'h1 : 32'h0);
            checkOutput($sformatf("tgl_rise%0d", i), 32'(rise[3][0]), (i % 2 == 0) ? 32'h1 : 32'h0);
            checkOutput($sformatf("tgl_fall%0d", i), 32'(fall[3][0]), (i % 2 == 0) ? 32'h0 : 32'h1);
            checkOutput($sformatf("tgl_both%0d", i), 32'(rise[3] & fall[3]), 32'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sr_flop_bank.md
Name: sr_flop_bank

Overview:
- Parametrised bank of WIDTH clocked SR flip-flops sharing clk/rst_n. Successor to the single-bit posedge SR flop.
- Adds a configurable S=R=1 resolution mode, clock enable, synchronous clear, a per-bit rise/fall edge pulse, and conflict monitoring (sticky flag plus saturating counter).
- Used wherever status/event bits are set and cleared by independent sources, e.g. interrupt-pending and error-latch registers.

Parameters:
- WIDTH, 8: number of independent SR channels (>=1).
- CONFLICT_MODE, 0: action on S=R=1. 0 = hold, 1 = set-dominant, 2 = reset-dominant, 3 = toggle. Any other value is treated as 0.
- RESET_VAL, {WIDTH{1'b0}}: value loaded into q by rst_n and by sclr.
- CNT_W, 8: width of the conflict counter (>=1).

Ports:
- clk  in  1  clock, rising edge active
- rst_n  in  1  asynchronous active-low reset
- en  in  1  clock enable for SR updates
- sclr  in  1  synchronous clear of q to RESET_VAL
- s  in  WIDTH  per-channel set
- r  in  WIDTH  per-channel reset
- err_clr  in  1  synchronous clear of conflict_seen and conflict_cnt
- q  out  WIDTH  registered state
- qb  out  WIDTH  combinational ~q
- rise  out  WIDTH  one-cycle pulse, bit i asserted in the cycle q[i] first reads 1 after being 0
- fall  out  WIDTH  one-cycle pulse, bit i asserted in the cycle q[i] first reads 0 after being 1
- conflict_seen  out  1  sticky, set on any counted conflict
- conflict_cnt  out  CNT_W  saturating count of conflict cycles

Behaviour:
- Reset: clk and rst_n are as already decided — reset rst_n, asynchronous, active-low; clock clk. While rst_n=0: q=RESET_VAL, qb=~RESET_VAL, rise=0, fall=0, conflict_seen=0, conflict_cnt=0.
- Reset mid-operation: takes effect immediately on assertion, regardless of clk.
- Release: first update occurs on the first rising clk edge with rst_n=1. No edge pulses are generated by reset itself.
- q priority per rising edge: sclr > en. All updates have 1-cycle latency.
- sclr=1: q <= RESET_VAL, ignoring s, r and en.
- sclr=0, en=0: q holds. s and r are ignored; no conflict is counted.
- sclr=0, en=1, per bit i:
  - s=0, r=0: hold.
  - s=0, r=1: q[i] <= 0.
  - s=1, r=0: q[i] <= 1.
  - s=1, r=1: resolved per CONFLICT_MODE (hold / 1 / 0 / ~q[i]).
- The output is never X. The S=R=1 case is always resolved deterministically.
- Edge pulses:
  - rise and fall are registered and computed from old q vs next q, so each pulse coincides with the first cycle the new q is visible.
  - They apply to every q change, including changes caused by sclr.
  - A bit never has rise and fall asserted together.
  - Both return to 0 the next cycle unless q changes again. Toggle mode with a persistent conflict produces alternating rise/fall every cycle.
- Conflict event: a cycle with en=1, sclr=0 and |(s & r)=1.
  - Counts once per cycle, regardless of how many bits conflict.
  - Counted in every CONFLICT_MODE, including the modes where the conflict is benign.
- Conflict monitor updates per rising edge:
  - err_clr=1, no event: conflict_seen <= 0, conflict_cnt <= 0.
  - err_clr=1, event in same cycle: the new event wins, so conflict_seen <= 1 and conflict_cnt <= 1.
  - err_clr=0, event: conflict_seen <= 1; conflict_cnt increments and saturates at 2^CNT_W-1 with no wrap.
  - err_clr=0, no event: both hold.
- err_clr does not affect q, rise or fall. sclr does not clear the conflict monitor.
- Arithmetic: the counter is unsigned CNT_W bits, and the saturation check compares against all-ones before incrementing.

Test Plan:
- Reset/defaults, WIDTH=8, RESET_VAL=8'hA5: hold rst_n=0 -> q=8'hA5, qb=8'h5A, all flags 0. Release, then idle 3 cycles -> no rise/fall pulses.
- Basic set/reset, en=1: s=8'h0F, r=0 for 1 cycle from q=0 -> q=8'h0F next cycle with rise=8'h0F for exactly 1 cycle. Then r=8'h03 -> q=8'h0C, fall=8'h03.
- Conflict modes: q=8'h0F, s=r=8'hFF, en=1, one cycle -> q is 8'h0F / 8'hFF / 8'h00 / 8'hF0 for modes 0/1/2/3. In every mode conflict_seen=1 and conflict_cnt=1.
- Enable/clear priority:
  - en=0 with s=8'hFF -> q unchanged, cnt unchanged.
  - sclr=1 with s=8'hFF, en=1 -> q=RESET_VAL, no conflict counted.
  - Assert rst_n low mid-cycle -> q=RESET_VAL immediately.
- Counter saturation, CNT_W=3: 10 consecutive conflict cycles -> cnt sequence 1..7, then holds at 7. err_clr alone -> cnt=0 and seen=0. err_clr together with a conflict -> cnt=1, seen=1.
- Toggle stress, mode 3: s=r=8'h01 held for 4 cycles from q=0 -> q[0]=1,0,1,0, with rise/fall alternating each cycle and never both high.
